// File: rtl/atm_pkg.sv
// Shared ATM datapath definitions: button indices, amount-entry FSM states,
// press actions and BCD digit helpers.
package atm_pkg;

    localparam int NUM_BTNS = 5;

    localparam int BTN_C = 0;
    localparam int BTN_U = 1;
    localparam int BTN_L = 2;
    localparam int BTN_R = 3;
    localparam int BTN_D = 4;

    typedef logic [3:0] bcd_t;
    localparam bcd_t MAX_DIGIT = 4'd9;

    typedef enum logic [1:0] {
        IDLE,
        EDIT,
        COMMIT
    } state_t;

    // The single press acted on in a cycle, after priority resolution.
    typedef enum logic [2:0] {
        ACT_NONE,
        ACT_COMMIT,
        ACT_UP,
        ACT_DOWN,
        ACT_LEFT,
        ACT_RIGHT
    } action_t;

    function automatic bcd_t bcd_inc(input bcd_t d);
        return (d >= MAX_DIGIT) ? 4'd0 : d + 4'd1;
    endfunction

    function automatic bcd_t bcd_dec(input bcd_t d);
        return (d == 4'd0) ? MAX_DIGIT : d - 4'd1;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// One push-button: 2-FF synchroniser, consecutive-sample debounce and a
// one-cycle press pulse on the accepted 0->1 transition.
module btn_debounce #(
    parameter int DB_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic level,
    output logic press
);

    localparam int CNT_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    logic             meta_q;
    logic             sync_q;
    logic             level_q;
    logic             press_q;
    logic [CNT_W-1:0] cnt_q;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of its neighbours regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta_q  <= 1'b0;
            sync_q  <= 1'b0;
            level_q <= 1'b0;
            press_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            meta_q  <= btn;
            sync_q  <= meta_q;
            press_q <= 1'b0;
            if (sync_q == level_q) begin
                // Any sample agreeing with the stable level restarts the run.
                cnt_q <= '0;
            end else if (cnt_q == CNT_LAST) begin
                cnt_q   <= '0;
                level_q <= sync_q;
                press_q <= sync_q;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign level = level_q;
    assign press = press_q;

endmodule

// File: rtl/btn_amount_entry.sv
// Five-button BCD amount entry with cursor editing and a one-cycle commit strobe.
// Optional cursor blinking output blank_o is enabled by BTN_AMOUNT_ENTRY_BLINK_EN.
module btn_amount_entry
    import atm_pkg::*;
#(
    parameter int NUM_DIGITS = 8,
    parameter int DB_CYCLES  = 1000000,
    parameter int BLINK_HALF = 25000000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_BTNS-1:0]     btn_i,
    output logic [4*NUM_DIGITS-1:0] data_o,
    output logic [2:0]              cursor_o,
    output logic                    flag,
    output logic                    editing
`ifdef BTN_AMOUNT_ENTRY_BLINK_EN
    ,
    output logic [NUM_DIGITS-1:0]   blank_o
`endif
);

    localparam logic [2:0] CUR_LAST = 3'(NUM_DIGITS - 1);

    if (NUM_DIGITS < 1 || NUM_DIGITS > 8) begin : g_bad_digits
        $error("NUM_DIGITS must be 1..8 to fit the 3-bit cursor");
    end
    if (DB_CYCLES < 1) begin : g_bad_db
        $error("DB_CYCLES must be at least 1");
    end

    logic [NUM_BTNS-1:0] press;
    // Stable levels are not needed by the editor; only press edges matter.
    logic [NUM_BTNS-1:0] unused_levels;

    for (genvar b = 0; b < NUM_BTNS; b++) begin : g_btn
        btn_debounce #(
            .DB_CYCLES(DB_CYCLES)
        ) u_debounce (
            .clk  (clk),
            .rst  (rst),
            .btn  (btn_i[b]),
            .level(unused_levels[b]),
            .press(press[b])
        );
    end

    action_t act;

    // NOTE: every always_comb output gets a default first; a path that leaves
    // a variable unassigned would infer a latch.
    always_comb begin
        act = ACT_NONE;
        if (press[BTN_C])      act = ACT_COMMIT;
        else if (press[BTN_U]) act = ACT_UP;
        else if (press[BTN_D]) act = ACT_DOWN;
        else if (press[BTN_L]) act = ACT_LEFT;
        else if (press[BTN_R]) act = ACT_RIGHT;
    end

    state_t                  state_q;
    state_t                  state_d;
    bcd_t [NUM_DIGITS-1:0]   digits_q;
    bcd_t [NUM_DIGITS-1:0]   digits_d;
    bcd_t [NUM_DIGITS-1:0]   edit_digits;
    logic [2:0]              cursor_q;
    logic [2:0]              cursor_d;
    logic [2:0]              edit_cursor;

    // Effect of the current action on the amount, independent of state.
    always_comb begin
        edit_digits = digits_q;
        edit_cursor = cursor_q;
        case (act)
            ACT_UP:    edit_digits[cursor_q] = bcd_inc(digits_q[cursor_q]);
            ACT_DOWN:  edit_digits[cursor_q] = bcd_dec(digits_q[cursor_q]);
            ACT_LEFT:  edit_cursor = (cursor_q == CUR_LAST) ? 3'd0 : cursor_q + 3'd1;
            ACT_RIGHT: edit_cursor = (cursor_q == 3'd0) ? CUR_LAST : cursor_q - 3'd1;
            default:   ;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        digits_d = digits_q;
        cursor_d = cursor_q;
        case (state_q)
            IDLE: begin
                // Centre alone never commits an amount nobody has touched.
                if (act != ACT_NONE && act != ACT_COMMIT) begin
                    state_d  = EDIT;
                    digits_d = edit_digits;
                    cursor_d = edit_cursor;
                end
            end
            EDIT: begin
                if (act == ACT_COMMIT) begin
                    state_d = COMMIT;
                end else begin
                    digits_d = edit_digits;
                    cursor_d = edit_cursor;
                end
            end
            COMMIT: begin
                state_d  = IDLE;
                digits_d = '0;
                cursor_d = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: the digit array is reset explicitly because an abandoned partial
    // amount must never reach the converter after a reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            digits_q <= '0;
            cursor_q <= '0;
        end else begin
            state_q  <= state_d;
            digits_q <= digits_d;
            cursor_q <= cursor_d;
        end
    end

    assign data_o   = digits_q;
    assign cursor_o = cursor_q;
    assign flag     = (state_q == COMMIT);
    assign editing  = (state_q == EDIT);

`ifdef BTN_AMOUNT_ENTRY_BLINK_EN
    localparam int BL_W = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam logic [BL_W-1:0] BL_LAST = BL_W'(BLINK_HALF - 1);

    logic [BL_W-1:0] blink_cnt_q;
    logic            phase_q;
    logic            press_taken;

    assign press_taken = ((state_q == EDIT) && (act != ACT_NONE)) ||
                         ((state_q == IDLE) && (act != ACT_NONE) && (act != ACT_COMMIT));

    // Restarting on each accepted press keeps the edited digit lit right away.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            blink_cnt_q <= '0;
            phase_q     <= 1'b0;
        end else if (press_taken) begin
            blink_cnt_q <= '0;
            phase_q     <= 1'b0;
        end else if (blink_cnt_q == BL_LAST) begin
            blink_cnt_q <= '0;
            phase_q     <= ~phase_q;
        end else begin
            blink_cnt_q <= blink_cnt_q + 1'b1;
        end
    end

    always_comb begin
        blank_o = '0;
        if (state_q == EDIT) begin
            blank_o[cursor_q] = phase_q;
        end
    end
`else
    if (BLINK_HALF < 1) begin : g_bad_blink
        $error("BLINK_HALF must be at least 1");
    end
`endif

endmodule

// File: tb/tb_btn_amount_entry.sv
// Self-checking bench for btn_amount_entry: a reference model pushes expected
// output changes (value and cycle) and a monitor pops them as the DUT changes.
module tb_btn_amount_entry;

    localparam logic [4:0] B_C = 5'b00001;
    localparam logic [4:0] B_U = 5'b00010;
    localparam logic [4:0] B_L = 5'b00100;
    localparam logic [4:0] B_R = 5'b01000;
    localparam logic [4:0] B_D = 5'b10000;
    localparam int LAT = 7;

    typedef struct packed {
        logic [31:0] data;
        logic [2:0]  cursor;
        logic        flag;
        logic        editing;
    } obs_t;

    typedef struct {
        obs_t o;
        int   cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [4:0]  btn_i = '0;
    logic [31:0] data_o;
    logic [2:0]  cursor_o;
    logic        flag;
    logic        editing;
`ifdef BTN_AMOUNT_ENTRY_BLINK_EN
    logic [7:0]  blank_o;
`endif

    int   n_pass = 0;
    int   n_total = 0;
    int   cyc = 0;
    bit   mon_en = 1'b0;
    obs_t prev = '0;
    exp_t sb[$];

    int   m_dig[8];
    int   m_cur;
    bit   m_edit;

    btn_amount_entry #(
        .NUM_DIGITS(8),
        .DB_CYCLES (4),
        .BLINK_HALF(8)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .btn_i   (btn_i),
        .data_o  (data_o),
        .cursor_o(cursor_o),
        .flag    (flag),
        .editing (editing)
`ifdef BTN_AMOUNT_ENTRY_BLINK_EN
        ,
        .blank_o (blank_o)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    // ---------------- reference model ----------------
    function automatic obs_t m_obs(input logic f, input logic e);
        logic [31:0] d;
        d = '0;
        for (int i = 0; i < 8; i++) d[4*i +: 4] = 4'(m_dig[i]);
        return {d, 3'(m_cur), f, e};
    endfunction

    task automatic model_reset;
        for (int i = 0; i < 8; i++) m_dig[i] = 0;
        m_cur  = 0;
        m_edit = 1'b0;
    endtask

    task automatic push(input obs_t o, input int c);
        exp_t e;
        e.o   = o;
        e.cyc = c;
        sb.push_back(e);
    endtask

    // Buttons rising at cycle t take effect LAT cycles later.
    task automatic model_press(input logic [4:0] m, input int t);
        if (m[0]) begin
            if (m_edit) begin
                push(m_obs(1'b1, 1'b0), t + LAT);
                model_reset();
                push(m_obs(1'b0, 1'b0), t + LAT + 1);
            end
        end else if (m != 5'b0) begin
            if (m[1])      m_dig[m_cur] = (m_dig[m_cur] + 1) % 10;
            else if (m[4]) m_dig[m_cur] = (m_dig[m_cur] + 9) % 10;
            else if (m[2]) m_cur = (m_cur + 1) % 8;
            else           m_cur = (m_cur + 7) % 8;
            m_edit = 1'b1;
            push(m_obs(1'b0, 1'b1), t + LAT);
        end
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        obs_t cur;
        exp_t e;
        cur = {data_o, cursor_o, flag, editing};
        if (mon_en && cur !== prev) begin
            n_total++;
            if (sb.size() == 0) begin
                $display("FAIL sb_unexpected: got data=%h cursor=%0d flag=%b editing=%b at cycle %0d, required no change",
                         cur.data, cur.cursor, cur.flag, cur.editing, cyc);
            end else begin
                e = sb.pop_front();
                if (cur !== e.o || cyc != e.cyc)
                    $display("FAIL sb_change: got data=%h cursor=%0d flag=%b editing=%b at cycle %0d, required data=%h cursor=%0d flag=%b editing=%b at cycle %0d",
                             cur.data, cur.cursor, cur.flag, cur.editing, cyc,
                             e.o.data, e.o.cursor, e.o.flag, e.o.editing, e.cyc);
                else
                    n_pass++;
            end
        end
        prev = cur;
    end

    // ---------------- stimulus ----------------
    task automatic press(input logic [4:0] m);
        @(negedge clk);
        btn_i = m;
        model_press(m, cyc);
        repeat (10) @(negedge clk);
        btn_i = '0;
        repeat (10) @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b0;
        btn_i = '0;
        model_reset();
        repeat (3) @(negedge clk);
        n_total++;
        if (data_o !== 32'h0) $display("FAIL reset_data: got %h required 00000000", data_o); else n_pass++;
        n_total++;
        if (cursor_o !== 3'd0) $display("FAIL reset_cursor: got %0d required 0", cursor_o); else n_pass++;
        n_total++;
        if (flag !== 1'b0 || editing !== 1'b0)
            $display("FAIL reset_flags: got flag=%b editing=%b required 0 0", flag, editing);
        else n_pass++;
        rst = 1'b1;
        repeat (5) @(negedge clk);
        #2 mon_en = 1'b1;
        press(B_U);
        n_total++;
        if (data_o !== 32'h1) $display("FAIL pre_reset_data: got %h required 00000001", data_o); else n_pass++;
        // Asynchronous reset must clear outputs before the next clock edge.
        #2 mon_en = 1'b0;
        rst = 1'b0;
        #1;
        n_total++;
        if ({data_o, cursor_o, flag, editing} !== 37'h0)
            $display("FAIL async_reset: got data=%h cursor=%0d flag=%b editing=%b required all 0",
                     data_o, cursor_o, flag, editing);
        else n_pass++;
        model_reset();
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (5) @(negedge clk);
        n_total++;
        if ({data_o, cursor_o, flag, editing} !== 37'h0)
            $display("FAIL reset_hold: got data=%h cursor=%0d flag=%b editing=%b required all 0",
                     data_o, cursor_o, flag, editing);
        else n_pass++;
        #2 mon_en = 1'b1;
        n_total++;
        if (sb.size() != 0) begin
            $display("FAIL reset_pending: %0d expected changes never seen, required 0", sb.size());
            sb.delete();
        end else n_pass++;
    endtask

    task automatic test_increment_commit;
        repeat (3) press(B_U);
        n_total++;
        if (data_o !== 32'h3 || editing !== 1'b1)
            $display("FAIL inc_edit: got data=%h editing=%b required 00000003 1", data_o, editing);
        else n_pass++;
        press(B_C);
        n_total++;
        if (data_o !== 32'h0 || editing !== 1'b0 || flag !== 1'b0)
            $display("FAIL inc_after_commit: got data=%h editing=%b flag=%b required 0 0 0", data_o, editing, flag);
        else n_pass++;
        n_total++;
        if (sb.size() != 0) begin
            $display("FAIL inc_pending: %0d expected changes never seen, required 0", sb.size());
            sb.delete();
        end else n_pass++;
    endtask

    task automatic test_wrap;
        press(B_D);
        n_total++;
        if (data_o !== 32'h9) $display("FAIL wrap_down: got %h required 00000009", data_o); else n_pass++;
        press(B_U);
        repeat (8) press(B_L);
        n_total++;
        if (cursor_o !== 3'd0 || data_o !== 32'h0)
            $display("FAIL wrap_left: got cursor=%0d data=%h required 0 00000000", cursor_o, data_o);
        else n_pass++;
        press(B_R);
        press(B_U);
        n_total++;
        if (data_o !== 32'h10000000 || cursor_o !== 3'd7)
            $display("FAIL wrap_msd: got data=%h cursor=%0d required 10000000 7", data_o, cursor_o);
        else n_pass++;
        press(B_C);
        n_total++;
        if (sb.size() != 0) begin
            $display("FAIL wrap_pending: %0d expected changes never seen, required 0", sb.size());
            sb.delete();
        end else n_pass++;
    endtask

    task automatic test_bounce;
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            btn_i = (i % 2 == 0) ? B_U : 5'b0;
            repeat (2) @(negedge clk);
        end
        btn_i = B_U;
        model_press(B_U, cyc);
        repeat (10) @(negedge clk);
        btn_i = '0;
        repeat (10) @(negedge clk);
        // A pulse shorter than the debounce window must be ignored.
        btn_i = B_U;
        repeat (3) @(negedge clk);
        btn_i = '0;
        repeat (15) @(negedge clk);
        n_total++;
        if (data_o !== 32'h1 || editing !== 1'b1)
            $display("FAIL bounce_data: got data=%h editing=%b required 00000001 1", data_o, editing);
        else n_pass++;
        n_total++;
        if (sb.size() != 0) begin
            $display("FAIL bounce_pending: %0d expected changes never seen, required 0", sb.size());
            sb.delete();
        end else n_pass++;
    endtask

    task automatic test_simultaneous;
        press(B_U | B_L);
        n_total++;
        if (data_o !== 32'h2 || cursor_o !== 3'd0)
            $display("FAIL simul_up_left: got data=%h cursor=%0d required 00000002 0", data_o, cursor_o);
        else n_pass++;
        press(B_C | B_U);
        n_total++;
        if (data_o !== 32'h0 || editing !== 1'b0)
            $display("FAIL simul_commit: got data=%h editing=%b required 0 0", data_o, editing);
        else n_pass++;
        n_total++;
        if (sb.size() != 0) begin
            $display("FAIL simul_pending: %0d expected changes never seen, required 0", sb.size());
            sb.delete();
        end else n_pass++;
    endtask

    task automatic test_reset_during_edit;
        int flag_cnt;
        press(B_L);
        repeat (5) press(B_U);
        press(B_L);
        repeat (4) press(B_U);
        n_total++;
        if (data_o !== 32'h450 || cursor_o !== 3'd2)
            $display("FAIL edit_450: got data=%h cursor=%0d required 00000450 2", data_o, cursor_o);
        else n_pass++;
        // Centre is in the debounce pipeline when reset hits; no commit may follow.
        @(negedge clk);
        btn_i = B_C;
        repeat (4) @(negedge clk);
        #2 mon_en = 1'b0;
        rst = 1'b0;
        model_reset();
        flag_cnt = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (flag) flag_cnt++;
            if (i == 2) rst = 1'b1;
            if (i == 20) btn_i = '0;
        end
        n_total++;
        if (flag_cnt != 0) $display("FAIL reset_no_flag: got %0d flag cycles required 0", flag_cnt); else n_pass++;
        n_total++;
        if (data_o !== 32'h0 || editing !== 1'b0)
            $display("FAIL reset_edit_clear: got data=%h editing=%b required 0 0", data_o, editing);
        else n_pass++;
        #2 mon_en = 1'b1;
        press(B_C);
        n_total++;
        if (flag !== 1'b0 || editing !== 1'b0 || data_o !== 32'h0)
            $display("FAIL idle_centre: got flag=%b editing=%b data=%h required 0 0 0", flag, editing, data_o);
        else n_pass++;
        n_total++;
        if (sb.size() != 0) begin
            $display("FAIL reset_edit_pending: %0d expected changes never seen, required 0", sb.size());
            sb.delete();
        end else n_pass++;
    endtask

    initial begin
        test_reset();
        test_increment_commit();
        test_wrap();
        test_bounce();
        test_simultaneous();
        test_reset_during_edit();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
